// File: rtl/data_line_responder_pkg.sv
// Shared types and field positions for the data line responder.
package data_line_responder_pkg;

  localparam int unsigned LINE_W    = 128;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned WORDS     = LINE_W / WORD_W;
  localparam int unsigned WORD_BITS = 2;
  localparam int unsigned WORD_LSB  = 2;
  localparam int unsigned LINE_LSB  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // One-hot word enable for a word offset within a line.
  function automatic logic [WORDS-1:0] word_sel(input logic [WORD_BITS-1:0] off);
    word_sel = WORDS'(1) << off;
  endfunction

endpackage

// File: rtl/data_line_array.sv
// Line storage: one asynchronous 128-bit read port, one word-enabled write port.
module data_line_array
  import data_line_responder_pkg::*;
#(
  parameter int unsigned LINES = 256,
  parameter int unsigned IW    = $clog2(LINES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [WORDS-1:0]  wen,
  input  logic [IW-1:0]     waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic [IW-1:0]     raddr,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [LINES];

  // Word-granular write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int w = 0; w < int'(WORDS); w++) begin
        if (wen[w]) begin
          mem[waddr][w*WORD_W +: WORD_W] <= wdata[w*WORD_W +: WORD_W];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_line_responder.sv
// Single-outstanding line responder: write-through words, fixed-latency line fills.
module data_line_responder
  import data_line_responder_pkg::*;
#(
  parameter int unsigned LINES   = 256,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [LINE_W-1:0] resp_line,
  output logic              resp_write
);

  localparam int unsigned IW    = $clog2(LINES);
  localparam int unsigned CNT_W = $clog2(LATENCY) + 1;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic [IW-1:0]     idx_q;
  logic              wr_q;

  logic              accept_c;
  logic              arr_we_c;
  logic [WORDS-1:0]  arr_wen_c;
  logic [LINE_W-1:0] arr_wdata_c;
  logic [LINE_W-1:0] arr_rdata_c;
  logic [IW-1:0]     req_idx_c;
  logic              unused_addr_c;

  assign req_idx_c     = req_addr[LINE_LSB +: IW];
  assign unused_addr_c = ^{req_addr[31:LINE_LSB+IW], req_addr[WORD_LSB-1:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and array write-port control.
  always_comb begin
    next_state  = state;
    accept_c    = 1'b0;
    arr_we_c    = 1'b0;
    arr_wen_c   = '0;
    arr_wdata_c = {WORDS{req_wdata}};
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept_c   = rst_n;
          next_state = WAIT;
        end
        arr_we_c  = accept_c && req_write;
        arr_wen_c = word_sel(req_addr[WORD_LSB +: WORD_BITS]);
      end
      WAIT: begin
        if (cnt == '0) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Latency counter and latched request fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx_q <= '0;
      wr_q  <= 1'b0;
    end else if (accept_c) begin
      cnt   <= CNT_W'(LATENCY - 1);
      idx_q <= req_idx_c;
      wr_q  <= req_write;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Registered handshake flags; line captured on the WAIT->RESP transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_line  <= '0;
    end else begin
      req_ready  <= (next_state == IDLE);
      resp_valid <= (next_state == RESP);
      if (state == WAIT && next_state == RESP) begin
        resp_line  <= arr_rdata_c;
        resp_write <= wr_q;
      end
    end
  end

  data_line_array #(
    .LINES (LINES),
    .IW    (IW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we_c),
    .wen   (arr_wen_c),
    .waddr (req_idx_c),
    .wdata (arr_wdata_c),
    .raddr (idx_q),
    .rdata (arr_rdata_c)
  );

endmodule

// File: tb/tb_data_line_responder.sv
// Directed bench for data_line_responder with default LINES/LATENCY.
module tb_data_line_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_line;
  logic         resp_write;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_line_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_line  (resp_line),
    .resp_write (resp_write)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one accept edge, then drop req_valid.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    check("req_ready_before_accept", 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    tick();
    req_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until resp_valid, bounded.
  task automatic wait_resp(input string tag);
    int n;
    n = 0;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, 128'(n), 128'(LAT));
  endtask

  task automatic handshake(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_valid_drop"}, 128'(resp_valid), 128'(0));
    check({tag, "_ready_back"}, 128'(req_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] held;
    logic         saw_valid;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;

    // Reset then idle.
    tick();
    tick();
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_resp_line", resp_line, 128'(0));
    check("rst_resp_write", 128'(resp_write), 128'(0));
    rst_n = 1'b1;
    tick();
    check("rst_release_ready", 128'(req_ready), 128'(1));
    check("rst_release_valid", 128'(resp_valid), 128'(0));

    // Write then fill.
    issue(1'b1, 32'h0000_0048, 32'hDEAD_BEEF);
    check("wr_wait_ready", 128'(req_ready), 128'(0));
    wait_resp("wr_latency");
    check("wr_resp_write", 128'(resp_write), 128'(1));
    check("wr_resp_word2", 128'(resp_line[95:64]), 128'(32'hDEAD_BEEF));
    handshake("wr");
    issue(1'b0, 32'h0000_0040, 32'h0);
    wait_resp("rd_latency");
    check("rd_resp_write", 128'(resp_write), 128'(0));
    check("rd_resp_word2", 128'(resp_line[95:64]), 128'(32'hDEAD_BEEF));
    handshake("rd");

    // Stall for 5 cycles with resp_ready low.
    issue(1'b0, 32'h0000_0040, 32'h0);
    wait_resp("stall_latency");
    held = resp_line;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 128'(resp_valid), 128'(1));
      check("stall_line", resp_line, held);
      check("stall_ready", 128'(req_ready), 128'(0));
    end
    check("stall_word2", 128'(resp_line[95:64]), 128'(32'hDEAD_BEEF));
    handshake("stall");

    // Ignored requests during WAIT and RESP.
    issue(1'b1, 32'h0000_0104, 32'hCAFE_F00D);
    wait_resp("pre_latency");
    handshake("pre");
    issue(1'b1, 32'h0000_0084, 32'h1234_5678);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0104;
    req_wdata = 32'h0000_0BAD;
    wait_resp("ign_latency");
    tick();
    check("ign_resp_ready", 128'(req_ready), 128'(0));
    check("ign_resp_word1", 128'(resp_line[63:32]), 128'(32'h1234_5678));
    check("ign_resp_write", 128'(resp_write), 128'(1));
    req_valid = 1'b0;
    handshake("ign");
    issue(1'b0, 32'h0000_0104, 32'h0);
    wait_resp("ign_rd_latency");
    check("ign_not_written", 128'(resp_line[63:32]), 128'(32'hCAFE_F00D));
    handshake("ign_rd");

    // Aliasing at the top line, with resp_ready held high before valid.
    issue(1'b1, 32'h0000_0FFC, 32'h1111_1111);
    wait_resp("alias_wr_latency");
    handshake("alias_wr");
    resp_ready = 1'b1;
    issue(1'b0, 32'h0000_1FF0, 32'h0);
    check("early_ready_no_effect", 128'(resp_valid), 128'(0));
    wait_resp("alias_latency");
    check("alias_word3", 128'(resp_line[127:96]), 128'(32'h1111_1111));
    tick();
    resp_ready = 1'b0;
    check("alias_valid_drop", 128'(resp_valid), 128'(0));
    check("alias_ready_back", 128'(req_ready), 128'(1));

    // Reset during WAIT of a write; the write stays committed.
    issue(1'b1, 32'h0000_0020, 32'hA5A5_A5A5);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_ready", 128'(req_ready), 128'(1));
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      saw_valid = saw_valid | resp_valid;
      tick();
    end
    check("midrst_no_resp", 128'(saw_valid), 128'(0));
    issue(1'b0, 32'h0000_0020, 32'h0);
    wait_resp("midrst_rd_latency");
    check("midrst_word0", 128'(resp_line[31:0]), 128'(32'hA5A5_A5A5));
    handshake("midrst_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_line_responder.md
DATA_LINE_RESPONDER -- requirements
Module: data_line_responder

Interface
REQ-001 Parameter LINES, default 256: number of 128-bit lines held; power of two, at least 2.
REQ-002 Parameter LATENCY, default 4: cycles from request acceptance to first resp_valid; at least 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  cache-side request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = word write-through, 0 = line fill read.
REQ-008 req_addr  input  32  byte address: [3:2] word offset, [4+IW-1:4] line index, where IW = log2(LINES).
REQ-009 req_wdata  input  32  write word, used only when req_write=1.
REQ-010 resp_valid  output  1  response line valid.
REQ-011 resp_ready  input  1  cache accepts the response.
REQ-012 resp_line  output  128  addressed line; word n occupies bits [32n+31:32n].
REQ-013 resp_write  output  1  echo of req_write for the response being presented.

Function
REQ-014 A request is accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-015 Only one request is outstanding at a time.
REQ-016 FSM states: IDLE, WAIT, RESP.
REQ-017 IDLE: req_ready=1, resp_valid=0; acceptance latches address, write flag and data, loads the latency counter with LATENCY-1, and moves to WAIT.
REQ-018 WAIT: req_ready=0, resp_valid=0; the counter decrements each cycle; at 0 the state moves to RESP, so resp_valid first rises exactly LATENCY cycles after the accept edge.
REQ-019 RESP: resp_valid=1, and resp_line and resp_write are held stable until resp_ready=1.
REQ-020 A handshake edge (resp_valid=1 and resp_ready=1) returns the FSM to IDLE; req_ready is 1 on the next cycle, and there is no same-cycle back-to-back acceptance.
REQ-021 The FSM ignores req_valid, req_write, req_addr and req_wdata outside IDLE.
REQ-022 A write stores req_wdata into word [3:2] of the indexed line on the accept edge.
REQ-023 A write response returns the updated line.
REQ-024 A read response returns the line content as of the WAIT->RESP transition.
REQ-025 Address bits above the index field and bits [1:0] are ignored; aliasing is permitted.
REQ-026 A resp_ready assertion while resp_valid=0 has no effect.
REQ-027 With LATENCY=1 the FSM goes directly from WAIT to RESP on the first WAIT cycle, and no counter underflow occurs.
REQ-028 The latency counter width is log2(LATENCY)+1 and the counter never wraps.

Reset
REQ-029 While rst_n=0 on a clock edge: state goes to IDLE and the counter clears.
REQ-030 While rst_n=0 on a clock edge: resp_valid=0, resp_write=0, resp_line=0, and req_ready becomes 1 on the first cycle after rst_n returns to 1.
REQ-031 Reset mid-WAIT or mid-RESP discards the pending response.
REQ-032 A write already committed on its accept edge stays committed after reset.
REQ-033 Line storage is not cleared by reset; its contents before the first write are undefined.

Structure
REQ-034 A shared package holds the FSM state enum (IDLE, WAIT, RESP), LINE_W=128, WORD_W=32, and the offset field position constants.
REQ-035 Line storage is a sub-module named data_line_array: one 128-bit read port, and one write port with a 4-bit word-enable.
REQ-036 The FSM, counter and response registers reside in data_line_responder.

Verification
REQ-037 Reset then idle: rst_n=0 for 2 cycles, then 1 -> resp_valid=0, resp_line=0, req_ready=1 on the first cycle after release.
REQ-038 Write then fill: write 0xDEADBEEF to address 0x00000048, handshake it, then read 0x00000040 with LATENCY=4 -> resp_valid rises 4 cycles after accept, and resp_line[95:64]=0xDEADBEEF.
REQ-039 Stall: read accepted with resp_ready=0 for 5 cycles -> resp_valid stays 1, resp_line stays stable, req_ready=0 throughout; resp_ready=1 -> IDLE next cycle.
REQ-040 Ignored requests: req_valid=1 with a different address during WAIT and RESP -> no second acceptance, and the response matches the first request.
REQ-041 Aliasing and boundaries: with LINES=256, write 0x11111111 to 0x00000FFC, then read 0x00001FF0 -> resp_line[127:96]=0x11111111.
REQ-042 Reset mid-operation: rst_n=0 during WAIT of a write to 0x20 -> resp_valid never asserts; a subsequent read of 0x20 returns the written word.
